// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock parametrised FIFO.
// The FIFO has an occupancy count, registered full/empty and almost-full/almost-empty flags,
// and either a registered-read mode (FWFT=0) or a first-word-fall-through mode (FWFT=1).
// Optional feature macro: SYNC_FIFO_ERR_FLAGS_EN adds sticky overflow/underflow flags
// and an err_clr input. When the macro is undefined, those ports and their logic are absent.
module sync_fifo_param #(
    parameter int DWIDTH    = 4,
    parameter int ADDR_W    = 7,
    parameter int AF_THRESH = 120,
    parameter int AE_THRESH = 8,
    parameter int FWFT      = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              winc,
    input  logic [DWIDTH-1:0] wdata,
    output logic              wfull,
    output logic              walmost_full,
    input  logic              rinc,
    output logic [DWIDTH-1:0] rdata,
    output logic              rempty,
    output logic              ralmost_empty,
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    input  logic              err_clr,
    output logic              overflow,
    output logic              underflow,
`endif
    output logic [ADDR_W:0]   count
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_THRESH);
    localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_THRESH);

    logic [DWIDTH-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wptr_reg, wptr_next;
    logic [ADDR_W-1:0] rptr_reg, rptr_next;
    logic [ADDR_W:0]   count_reg, count_next;
    logic              wr_en, rd_en;
    logic              wfull_reg, rempty_reg;
    logic              walmost_full_reg, ralmost_empty_reg;
    logic [DWIDTH-1:0] rdata_reg;

    // Accept/reject decisions use the registered flags; the next pointers and next count follow from them.
    always_comb begin
        wr_en      = winc && !wfull_reg;
        rd_en      = rinc && !rempty_reg;
        wptr_next  = wr_en ? wptr_reg + 1'b1 : wptr_reg;
        rptr_next  = rd_en ? rptr_reg + 1'b1 : rptr_reg;
        count_next = count_reg;
        if (wr_en && !rd_en) begin
            count_next = count_reg + 1'b1;
        end else if (!wr_en && rd_en) begin
            count_next = count_reg - 1'b1;
        end
    end

    // Pointers, count and flags. The flags are computed from the next count so they line up with count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_reg          <= '0;
            rptr_reg          <= '0;
            count_reg         <= '0;
            wfull_reg         <= 1'b0;
            rempty_reg        <= 1'b1;
            walmost_full_reg  <= 1'b0;
            ralmost_empty_reg <= 1'b1;
        end else begin
            wptr_reg          <= wptr_next;
            rptr_reg          <= rptr_next;
            count_reg         <= count_next;
            wfull_reg         <= (count_next == DEPTH_C);
            rempty_reg        <= (count_next == '0);
            walmost_full_reg  <= (count_next >= AF_C);
            ralmost_empty_reg <= (count_next <= AE_C);
        end
    end

    // Storage array. Its contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[wptr_reg] <= wdata;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // The head register always tracks the entry at the next read pointer. When that entry
            // is being written in this same cycle (the FIFO was empty, or one entry is being popped
            // while another is pushed), the incoming word is forwarded instead of the stale array
            // contents. While the FIFO goes or stays empty, the register holds its last value.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata_reg <= '0;
                end else if (count_next != '0) begin
                    if (wr_en && (wptr_reg == rptr_next)) begin
                        rdata_reg <= wdata;
                    end else begin
                        rdata_reg <= mem[rptr_next];
                    end
                end
            end
        end else begin : g_std
            // Registered read: the word appears one cycle after an accepted pop.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata_reg <= '0;
                end else if (rd_en) begin
                    rdata_reg <= mem[rptr_reg];
                end
            end
        end
    endgenerate

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic overflow_reg, underflow_reg;

    // Sticky error flags. A new error takes precedence over a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (winc && wfull_reg) begin
                overflow_reg <= 1'b1;
            end else if (err_clr) begin
                overflow_reg <= 1'b0;
            end
            if (rinc && rempty_reg) begin
                underflow_reg <= 1'b1;
            end else if (err_clr) begin
                underflow_reg <= 1'b0;
            end
        end
    end

    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;
`endif

    assign wfull         = wfull_reg;
    assign rempty        = rempty_reg;
    assign walmost_full  = walmost_full_reg;
    assign ralmost_empty = ralmost_empty_reg;
    assign rdata         = rdata_reg;
    assign count         = count_reg;

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: bench for sync_fifo_param with default parameters (registered read),
// plus a second instance with FWFT=1. A queue scoreboard models the expected contents.
module tb_sync_fifo_param;

    localparam int DW    = 4;
    localparam int AW    = 7;
    localparam int DEPTH = 128;
    localparam int AF    = 120;
    localparam int AE    = 8;

    logic clk = 1'b0;
    logic rst;

    logic          winc, rinc;
    logic [DW-1:0] wdata, rdata;
    logic          wfull, walmost_full, rempty, ralmost_empty;
    logic [AW:0]   count;

    logic          f_winc, f_rinc;
    logic [DW-1:0] f_wdata, f_rdata;
    logic          f_wfull, f_walmost_full, f_rempty, f_ralmost_empty;
    logic [AW:0]   f_count;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic err_clr, overflow, underflow;
    logic f_err_clr, f_overflow, f_underflow;
`endif

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] q[$];
    int            mcount;
    logic [DW-1:0] mrdata;
    logic          movf, mudf;

    always #5 clk = ~clk;

    sync_fifo_param #(.DWIDTH(DW), .ADDR_W(AW), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)) dut (
        .clk(clk), .rst(rst),
        .winc(winc), .wdata(wdata), .wfull(wfull), .walmost_full(walmost_full),
        .rinc(rinc), .rdata(rdata), .rempty(rempty), .ralmost_empty(ralmost_empty),
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        .err_clr(err_clr), .overflow(overflow), .underflow(underflow),
`endif
        .count(count)
    );

    sync_fifo_param #(.DWIDTH(DW), .ADDR_W(AW), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)) dut_fw (
        .clk(clk), .rst(rst),
        .winc(f_winc), .wdata(f_wdata), .wfull(f_wfull), .walmost_full(f_walmost_full),
        .rinc(f_rinc), .rdata(f_rdata), .rempty(f_rempty), .ralmost_empty(f_ralmost_empty),
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        .err_clr(f_err_clr), .overflow(f_overflow), .underflow(f_underflow),
`endif
        .count(f_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_state();
        check("count", count, mcount);
        check("rempty", rempty, mcount == 0);
        check("wfull", wfull, mcount == DEPTH);
        check("walmost_full", walmost_full, mcount >= AF);
        check("ralmost_empty", ralmost_empty, mcount <= AE);
        check("rdata", rdata, mrdata);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        check("overflow", overflow, movf);
        check("underflow", underflow, mudf);
`endif
    endtask

    // One clock of stimulus on the main instance, followed by a model update and checks.
    task automatic cyc(input logic w, input logic [DW-1:0] wd, input logic r, input logic clr);
        logic wa, ra;
        winc  = w;
        wdata = wd;
        rinc  = r;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        err_clr = clr;
`endif
        wa = w && (mcount != DEPTH);
        ra = r && (mcount != 0);
        @(posedge clk);
        #1;
        if (w && mcount == DEPTH) movf = 1'b1;
        else if (clr) movf = 1'b0;
        if (r && mcount == 0) mudf = 1'b1;
        else if (clr) mudf = 1'b0;
        if (ra) mrdata = q.pop_front();
        if (wa) q.push_back(wd);
        mcount = q.size();
        winc = 1'b0;
        rinc = 1'b0;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        err_clr = 1'b0;
`endif
        check_state();
    endtask

    task automatic do_reset(input logic w, input logic r);
        rst   = 1'b1;
        winc  = w;
        rinc  = r;
        wdata = 4'hF;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        winc = 1'b0;
        rinc = 1'b0;
        q.delete();
        mcount = 0;
        mrdata = '0;
        movf   = 1'b0;
        mudf   = 1'b0;
        check_state();
    endtask

    task automatic fw_step(input logic w, input logic [DW-1:0] wd, input logic r);
        f_winc  = w;
        f_wdata = wd;
        f_rinc  = r;
        @(posedge clk);
        #1;
        f_winc = 1'b0;
        f_rinc = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        winc = 0; rinc = 0; wdata = 0;
        f_winc = 0; f_rinc = 0; f_wdata = 0;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        err_clr = 0; f_err_clr = 0;
`endif
        mcount = 0; mrdata = 0; movf = 0; mudf = 0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        do_reset(1'b0, 1'b0);
        cyc(0, 0, 0, 0);
        check("fw_reset_rempty", f_rempty, 1);
        check("fw_reset_rdata", f_rdata, 0);
        check("fw_reset_count", f_count, 0);

        // Write 1..10, then read them back with registered-read latency.
        for (int i = 1; i <= 10; i++) cyc(1, DW'(i), 0, 0);
        for (int i = 1; i <= 10; i++) cyc(0, 0, 1, 0);
        check("drain_last", rdata, 4'hA);

        // Read while empty, then clear the error flag.
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 1);

        // Same-cycle write and read while empty: only the write is accepted.
        cyc(1, 4'h3, 1, 0);
        cyc(0, 0, 1, 0);

        // Fill to full, then push once more; also write while full with a read in the same cycle.
        for (int i = 0; i < DEPTH; i++) cyc(1, DW'($urandom_range(0, 15)), 0, 0);
        cyc(1, 4'h7, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 1);
        cyc(1, 4'h9, 1, 0);

        // Drain to 64, then stream 200 cycles of simultaneous write+read through both pointer wraps.
        while (mcount > 64) cyc(0, 0, 1, 0);
        for (int i = 0; i < 200; i++) cyc(1, DW'($urandom_range(0, 15)), 1, 0);
        check("stream_count", count, 64);

        // Move to 50 entries, then reset while both requests are active.
        while (mcount > 50) cyc(0, 0, 1, 0);
        do_reset(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1, DW'(4'hC + i), 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0);

        // First-word-fall-through instance.
        fw_step(1, 4'h5, 0);
        check("fw_wr_rempty", f_rempty, 0);
        check("fw_wr_rdata", f_rdata, 4'h5);
        check("fw_wr_count", f_count, 1);
        fw_step(0, 0, 1);
        check("fw_pop_rempty", f_rempty, 1);
        check("fw_pop_count", f_count, 0);
        check("fw_pop_hold", f_rdata, 4'h5);
        fw_step(0, 0, 1);
        check("fw_under_count", f_count, 0);
        check("fw_under_hold", f_rdata, 4'h5);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        check("fw_underflow", f_underflow, 1);
`endif
        fw_step(1, 4'h1, 0);
        fw_step(1, 4'h2, 0);
        fw_step(1, 4'h3, 0);
        check("fw_head1", f_rdata, 4'h1);
        check("fw_count3", f_count, 3);
        fw_step(0, 0, 1);
        check("fw_head2", f_rdata, 4'h2);
        fw_step(0, 0, 1);
        check("fw_head3", f_rdata, 4'h3);
        fw_step(1, 4'h9, 1);
        check("fw_bypass", f_rdata, 4'h9);
        check("fw_bypass_count", f_count, 1);
        fw_step(0, 0, 1);
        check("fw_last_rempty", f_rempty, 1);
        check("fw_last_hold", f_rdata, 4'h9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
